// File: rtl/graphics_pkg.sv
// Shared state encoding and constants for the sprite-drawing sequencer.
package graphics_pkg;

  localparam int unsigned GFX_PIXELS = 64;
  localparam logic [2:0]  GFX_WHITE  = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_DRAW    = 4'd2,
    S_FLASH   = 4'd3,
    S_FDRAW   = 4'd4,
    S_HOLD    = 4'd5,
    S_RESTORE = 4'd6,
    S_RDRAW   = 4'd7,
    S_DONE    = 4'd8
  } gfx_state_e;

  // States in which one pixel is emitted per cycle.
  function automatic logic gfx_is_draw(input gfx_state_e s);
    return (s == S_DRAW) || (s == S_FDRAW) || (s == S_RDRAW);
  endfunction

endpackage

// File: rtl/gfx_hold_timer.sv
// Hold timer for the white-flash phase: cleared by start, counts while run,
// expire is high on the last of HOLD_CYCLES counted cycles.
module gfx_hold_timer
  import graphics_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 12_500_000,
  parameter int unsigned HOLD_W      = 24
) (
  input  logic clock,
  input  logic resetn,
  input  logic start,
  input  logic run,
  output logic expire
);

  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clock) begin
    if (!resetn || start) begin
      hold_cnt <= '0;
    end else if (run) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign expire = run && (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/graphics_control.sv
// Moore sequencer for the 8x8 sprite datapath and VGA writeEn.
// Define GFX_FLASH_EN to build the flash / hold / restore phase.
module graphics_control
  import graphics_pkg::*;
#(
  parameter int unsigned PIXELS      = GFX_PIXELS,
  parameter int unsigned HOLD_CYCLES = 12_500_000,
  parameter int unsigned HOLD_W      = 24
) (
  input  logic clock,
  input  logic resetn,
  input  logic go,
  input  logic flash_req,
  output logic ld_load,
  output logic ld_enable,
  output logic ld_flash,
  output logic ld_previous,
  output logic plot,
  output logic busy,
  output logic done
);

  localparam int unsigned PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  gfx_state_e       state, nxt;
  logic [PIX_W-1:0] pix_cnt;
  logic             pix_last;
  logic             flash_q;

  assign pix_last = (pix_cnt == PIX_W'(PIXELS - 1));

`ifdef GFX_FLASH_EN
  logic hold_expire;

  gfx_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .HOLD_W      (HOLD_W)
  ) u_hold_timer (
    .clock  (clock),
    .resetn (resetn),
    .start  (state != S_HOLD),
    .run    (state == S_HOLD),
    .expire (hold_expire)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      flash_q <= 1'b0;
    end else if (state == S_IDLE && go) begin
      flash_q <= flash_req;
    end
  end
`else
  logic unused_flash_req;
  localparam int unsigned unused_hold_cfg = HOLD_CYCLES + HOLD_W;

  assign unused_flash_req = flash_req;
  assign flash_q          = 1'b0;
  assign ld_flash         = 1'b0;
  assign ld_previous      = 1'b0;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (go) nxt = S_LOAD;
      S_LOAD:    nxt = S_DRAW;
      S_DRAW:    if (pix_last) nxt = flash_q ? S_FLASH : S_DONE;
`ifdef GFX_FLASH_EN
      S_FLASH:   nxt = S_FDRAW;
      S_FDRAW:   if (pix_last) nxt = S_HOLD;
      S_HOLD:    if (hold_expire) nxt = S_RESTORE;
      S_RESTORE: nxt = S_RDRAW;
      S_RDRAW:   if (pix_last) nxt = S_DONE;
`endif
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register itself while staying glitch-free.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= S_IDLE;
      pix_cnt     <= '0;
      ld_load     <= 1'b0;
      ld_enable   <= 1'b0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef GFX_FLASH_EN
      ld_flash    <= 1'b0;
      ld_previous <= 1'b0;
`endif
    end else begin
      state       <= nxt;
      pix_cnt     <= (gfx_is_draw(state) && !pix_last) ? pix_cnt + 1'b1 : '0;
      ld_load     <= (nxt == S_LOAD);
      ld_enable   <= (nxt == S_LOAD) || gfx_is_draw(nxt);
      plot        <= gfx_is_draw(nxt);
      busy        <= (nxt != S_IDLE);
      done        <= (nxt == S_DONE);
`ifdef GFX_FLASH_EN
      ld_flash    <= (nxt == S_FLASH);
      ld_previous <= (nxt == S_RESTORE);
`endif
    end
  end

endmodule

// File: tb/tb_graphics_control.sv
// Self-checking bench for graphics_control; expectations come from a
// per-transaction timeline built from the behavioural description.
module tb_graphics_control;

  localparam int unsigned HOLD = 4;
  localparam int unsigned PIX  = 64;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic go = 1'b0;
  logic flash_req = 1'b0;
  logic ld_load, ld_enable, ld_flash, ld_previous, plot, busy, done;

  graphics_control #(
    .PIXELS      (PIX),
    .HOLD_CYCLES (HOLD),
    .HOLD_W      (4)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .go          (go),
    .flash_req   (flash_req),
    .ld_load     (ld_load),
    .ld_enable   (ld_enable),
    .ld_flash    (ld_flash),
    .ld_previous (ld_previous),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Vector order: {ld_load, ld_enable, ld_flash, ld_previous, plot, busy, done}
  localparam logic [6:0] V_LOAD  = 7'b1100010;
  localparam logic [6:0] V_DRAW  = 7'b0100110;
  localparam logic [6:0] V_FLASH = 7'b0010010;
  localparam logic [6:0] V_HOLD  = 7'b0000010;
  localparam logic [6:0] V_PREV  = 7'b0001010;
  localparam logic [6:0] V_DONE  = 7'b0000011;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [6:0]  exp_q[$];
  logic [6:0]  cur_exp = '0;
  int unsigned cyc, plots, dones;

  function automatic logic [6:0] observed();
    return {ld_load, ld_enable, ld_flash, ld_previous, plot, busy, done};
  endfunction

  function automatic bit flash_taken(input logic f);
`ifdef GFX_FLASH_EN
    return f;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic push_txn(input logic f);
    exp_q.push_back(V_LOAD);
    repeat (PIX) exp_q.push_back(V_DRAW);
    if (flash_taken(f)) begin
      exp_q.push_back(V_FLASH);
      repeat (PIX) exp_q.push_back(V_DRAW);
      repeat (HOLD) exp_q.push_back(V_HOLD);
      exp_q.push_back(V_PREV);
      repeat (PIX) exp_q.push_back(V_DRAW);
    end
    exp_q.push_back(V_DONE);
  endtask

  // One clock: drive at the falling edge, update the model on the rising
  // edge, sample 1 ns later.
  task automatic step(input logic g, input logic f, input logic r);
    go = g; flash_req = f; resetn = r;
    @(posedge clock);
    if (!r) begin
      exp_q.delete();
      cur_exp = '0;
    end else begin
      if (!cur_exp[1] && g) push_txn(f);
      cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 7'b0;
    end
    #1;
    check("outputs", {25'b0, observed()}, {25'b0, cur_exp});
    check("load_prev_excl", {31'b0, ld_load & ld_previous}, 32'd0);
    check("flash_enable_excl", {31'b0, ld_flash & ld_enable}, 32'd0);
    cyc++;
    plots += plot;
    dones += done;
    #4;
  endtask

  task automatic clr();
    cyc = 0; plots = 0; dones = 0;
  endtask

  task automatic wait_done(input bit noise);
    while (dones == 0 && cyc < 600)
      step(noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic check_txn(input string tag, input logic f);
    bit fl = flash_taken(f);
    check({tag, "_done_cycle"}, cyc, fl ? 196 + HOLD : 66);
    check({tag, "_plots"}, plots, fl ? 3 * PIX : PIX);
    check({tag, "_dones"}, dones, 1);
    step(1'b0, 1'b0, 1'b1);
    check({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // Reset held with go high, then released with go still high.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_outs", {25'b0, observed()}, 32'd0);
    clr();
    step(1'b1, 1'b0, 1'b1);
    check("release_load", {31'b0, ld_load}, 32'd1);
    wait_done(1'b0);
    check_txn("plain", 1'b0);

    // Flash request (ignored when the flash build is absent).
    clr();
    step(1'b1, 1'b1, 1'b1);
    wait_done(1'b0);
    check_txn("flash", 1'b1);

    // go pulse in the middle of DRAW is ignored.
    clr();
    step(1'b1, 1'b0, 1'b1);
    while (dones == 0 && cyc < 600) step(cyc == 31, 1'b0, 1'b1);
    check_txn("go_mid_draw", 1'b0);

    // go held high: one IDLE cycle, then a fresh LOAD.
    clr();
    step(1'b1, 1'b0, 1'b1);
    while (dones == 0 && cyc < 600) step(1'b1, 1'b0, 1'b1);
    check("b2b_first_done", cyc, 66);
    step(1'b1, 1'b0, 1'b1);
    check("b2b_gap_idle", {31'b0, busy}, 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("b2b_reload", {31'b0, ld_load}, 32'd1);
    clr();
    cyc = 1;
    wait_done(1'b0);
    check_txn("b2b_second", 1'b0);

    // Reset mid-operation (inside HOLD when flash is built): no done pulse.
    clr();
    step(1'b1, 1'b1, 1'b1);
`ifdef GFX_FLASH_EN
    while (cyc < 133) step(1'b0, 1'b0, 1'b1);
    check("hold_before_abort", {25'b0, observed()}, {25'b0, V_HOLD});
`else
    while (cyc < 40) step(1'b0, 1'b0, 1'b1);
`endif
    step(1'b1, 1'b0, 1'b0);
    check("abort_no_done", dones, 0);
    check("abort_idle", {31'b0, busy}, 32'd0);
    clr();
    step(1'b1, 1'b0, 1'b1);
    wait_done(1'b0);
    check_txn("after_abort", 1'b0);

    // Randomised transactions with random gaps and input noise while busy.
    for (int i = 0; i < 8; i++) begin
      logic f;
      f = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
      clr();
      step(1'b1, f, 1'b1);
      wait_done(1'($urandom_range(0, 1)));
      check_txn("random", f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
